div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Sequencing controller for the switch-driven integer divider. Latches dividend/divisor from the switch bank, runs a W-cycle restoring shift/subtract division, and publishes quotient and remainder with busy/done status.
- Sits between the SW inputs and the LED / seven-segment display path inside principal.
- Supports an explicit start pulse and an auto-restart mode, so a bench that only drives SW still produces results.

Parameters:
- W, 4: operand width; dividend = SW[2W-1:W], divisor = SW[W-1:0].
- AUTO, 1: 1 = any operand change seen in IDLE or DONE acts as a start; 0 = only the start input starts a division.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- btnres  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  synchronous start request, level-sampled.
- dividend  in  W  numerator operand.
- divisor  in  W  denominator operand.
- busy  out  1  high in LOAD and CALC.
- done  out  1  high while results are valid (DONE state).
- quotient  out  W  result quotient.
- remainder  out  W  result remainder.
- dz  out  1  divide-by-zero flag for the current result.

Behaviour:
- Reset (btnres=0, async): state=IDLE, busy=0, done=0, quotient=0, remainder=0, dz=0, internal operand shadows=0, counter=0.
- States: IDLE, LOAD, CALC, DONE.
- Trigger: go = start | (AUTO & ({dividend,divisor} != shadow)). Evaluated only in IDLE and DONE. go in any other state is ignored; no queuing.
- IDLE/DONE with go: next state LOAD. Capture dividend/divisor into shadow and working registers. Clear done and dz.
- LOAD (1 cycle):
  - If divisor shadow == 0: next state DONE, dz=1, quotient = all ones, remainder = dividend.
  - Otherwise: R = 0 ((W+1) bits), Q = dividend, cnt = W-1, next state CALC.
- CALC (exactly W cycles), each cycle:
  - T = {R[W-1:0], Q[W-1]}.
  - If T >= {1'b0, D}: R = T - D, Q = {Q[W-2:0], 1}. Else: R = T, Q = {Q[W-2:0], 0}.
  - Compare and subtract are unsigned, at W+1 bits.
  - When cnt == 0: next state DONE, quotient = Q, remainder = R[W-1:0]. Otherwise cnt--.
- DONE: done=1; quotient, remainder and dz are held stable until the next go.
- Latency: the go edge enters LOAD; done rises W+2 rising edges after the go edge (6 for W=4). A divide-by-zero result arrives 2 edges after go.
- Outputs change only on the DONE transition or on reset, never mid-CALC. Display consumers read the held values.
- Operand change during LOAD/CALC: ignored for the current run. With AUTO=1 it is picked up in DONE, which restarts on the next cycle.
- start held high continuously: restarts from every DONE. done pulses for 1 cycle every W+2 cycles.
- Reset mid-CALC: immediate abort to reset values. No partial result is published.
- Boundaries: dividend=0 gives q=0, r=0. divisor=1 gives q=dividend, r=0. dividend < divisor gives q=0, r=dividend. Max operands (15/15) give q=1, r=0.

Decomposition:
- Shared package div_pkg holds: state encoding constants (S_IDLE=0, S_LOAD=1, S_CALC=2, S_DONE=3), default W, and a DZ_QUOT constant (all ones).
- One natural sub-module: div_step. It is combinational and takes R, Q, D to produce next R, next Q for one restoring iteration. The FSM, counter and shadows stay in div_seq_ctrl.
- Estimated 150–250 lines of RTL total.

Test Plan:
- Reset: btnres=0 while start=1 and SW toggles → all outputs 0, state IDLE. Release btnres; with AUTO=1 and SW=8'b00100001, a run starts → done after 6 edges, q=2, r=0.
- start pulse, AUTO=0, dividend=13, divisor=4 → busy high for 5 cycles, then done=1, q=3, r=1, dz=0. Values held 20 cycles with no further starts.
- divisor=0, dividend=9, start → done 2 edges after start, dz=1, q=4'hF, r=9. Next run with divisor=3 clears dz → q=3, r=0.
- Operand change mid-CALC (7/2 → 15/15 on the 2nd CALC cycle), AUTO=1 → first done shows q=3, r=1. Auto restart follows; second done shows q=1, r=0.
- btnres low for 1 cycle mid-CALC → outputs 0 immediately, done never asserts for the aborted run. A new start after release gives a correct result.
- Exhaustive sweep of all 256 SW values, AUTO=0, start per value → q and r match a reference model of dividend/divisor and dividend%divisor (dz for divisor=0).

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: FSM encoding,
// default operand width and the quotient reported on divide-by-zero.
package div_pkg;

    localparam int DEF_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Sliced down to the operand width by the user, so any W up to 32 reads all ones.
    localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring shift/subtract iteration: shift next dividend bit into R, trial-subtract D.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module div_step #(
    parameter int W = 4
) (
    input  logic [W:0]   r,
    input  logic [W-1:0] q,
    input  logic [W-1:0] d,
    output logic [W:0]   r_nxt,
    output logic [W-1:0] q_nxt
);

    logic [W:0] t;
    logic [W:0] d_ext;
    logic       ge;
    // A restored partial remainder is always below D, so its top bit is always zero.
    logic       unused_msb;

    assign unused_msb = r[W];
    assign t          = {r[W-1:0], q[W-1]};
    assign d_ext      = {1'b0, d};
    assign ge         = (t >= d_ext);
    assign r_nxt      = ge ? (t - d_ext) : t;
    assign q_nxt      = {q[W-2:0], ge};

endmodule

// File: rtl/div_seq_ctrl.sv
// Latches switch operands and runs a W-cycle restoring division, publishing quotient/remainder.
// Latency: LOAD plus W CALC cycles (W+2 edges counting the start edge); divide-by-zero in 2.
// Backpressure: none; start or operand changes are only honoured in IDLE/DONE, never queued.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter bit AUTO = 1'b1
) (
    input  logic         clk,
    input  logic         btnres,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         dz
);

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
    localparam logic [W-1:0]  DZQ      = DZ_QUOT[W-1:0];

    logic [1:0]    state;
    logic [W-1:0]  sh_dvd;
    logic [W-1:0]  sh_dvs;
    logic [W:0]    r_q;
    logic [W-1:0]  q_q;
    logic [CW-1:0] cnt;
    logic [W:0]    r_nxt;
    logic [W-1:0]  q_nxt;
    logic          go;

    // Shadows double as the change detector for auto-restart.
    assign go   = start | (AUTO & ({dividend, divisor} != {sh_dvd, sh_dvs}));
    assign busy = (state == S_LOAD) || (state == S_CALC);
    assign done = (state == S_DONE);

    div_step #(.W(W)) u_step (
        .r     (r_q),
        .q     (q_q),
        .d     (sh_dvs),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    always_ff @(posedge clk or negedge btnres) begin
        if (!btnres) begin
            state     <= S_IDLE;
            sh_dvd    <= '0;
            sh_dvs    <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        state  <= S_LOAD;
                        sh_dvd <= dividend;
                        sh_dvs <= divisor;
                        q_q    <= dividend;
                        r_q    <= '0;
                        dz     <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (sh_dvs == '0) begin
                        state     <= S_DONE;
                        dz        <= 1'b1;
                        quotient  <= DZQ;
                        remainder <= sh_dvd;
                    end else begin
                        r_q   <= '0;
                        q_q   <= sh_dvd;
                        cnt   <= CNT_INIT;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_q <= r_nxt;
                    q_q <= q_nxt;
                    if (cnt == '0) begin
                        state     <= S_DONE;
                        quotient  <= q_nxt;
                        remainder <= r_nxt[W-1:0];
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: one auto-restart instance and one start-only instance
// share clock and reset; each scenario task drives stimulus and compares inline.
module tb_div_seq_ctrl;

    logic       clk = 1'b0;
    logic       btnres;
    int         checks = 0;
    int         errors = 0;

    logic       a_start, a_busy, a_done, a_dz;
    logic [3:0] a_dvd, a_dvs, a_q, a_r;
    logic       m_start, m_busy, m_done, m_dz;
    logic [3:0] m_dvd, m_dvs, m_q, m_r;

    always #5 clk = ~clk;

    div_seq_ctrl #(.W(4), .AUTO(1'b1)) ua (
        .clk       (clk),
        .btnres    (btnres),
        .start     (a_start),
        .dividend  (a_dvd),
        .divisor   (a_dvs),
        .busy      (a_busy),
        .done      (a_done),
        .quotient  (a_q),
        .remainder (a_r),
        .dz        (a_dz)
    );

    div_seq_ctrl #(.W(4), .AUTO(1'b0)) um (
        .clk       (clk),
        .btnres    (btnres),
        .start     (m_start),
        .dividend  (m_dvd),
        .divisor   (m_dvs),
        .busy      (m_busy),
        .done      (m_done),
        .quotient  (m_q),
        .remainder (m_r),
        .dz        (m_dz)
    );

    // Counts rising edges until done on the start-only instance; drops start after the first edge.
    task automatic wait_done_m(output int edges, output int busy_cnt);
        bit found = 1'b0;
        edges    = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(posedge clk);
            #1;
            m_start = 1'b0;
            if (m_busy) busy_cnt++;
            if (m_done) begin
                found = 1'b1;
                edges = i;
            end
        end
    endtask

    task automatic wait_done_a(output int edges, output int busy_cnt);
        bit found = 1'b0;
        edges    = -1;
        busy_cnt = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (a_busy) busy_cnt++;
            if (a_done) begin
                found = 1'b1;
                edges = i;
            end
        end
    endtask

    task automatic test_reset();
        int e, b;
        btnres  = 1'b0;
        a_start = 1'b1;
        m_start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_dvd = 4'(i + 5);
            a_dvs = 4'(i + 1);
            m_dvd = 4'(9 - i);
            m_dvs = 4'(i);
        end
        @(negedge clk);
        checks++; if ({a_busy, a_done, a_dz} !== 3'b000) begin errors++; $display("FAIL reset_a_status: got %b expected 000", {a_busy, a_done, a_dz}); end
        checks++; if (a_q !== 4'd0) begin errors++; $display("FAIL reset_a_q: got %0d expected 0", a_q); end
        checks++; if (a_r !== 4'd0) begin errors++; $display("FAIL reset_a_r: got %0d expected 0", a_r); end
        checks++; if ({m_busy, m_done, m_dz} !== 3'b000) begin errors++; $display("FAIL reset_m_status: got %b expected 000", {m_busy, m_done, m_dz}); end
        checks++; if (m_q !== 4'd0) begin errors++; $display("FAIL reset_m_q: got %0d expected 0", m_q); end
        checks++; if (m_r !== 4'd0) begin errors++; $display("FAIL reset_m_r: got %0d expected 0", m_r); end

        a_start = 1'b0;
        m_start = 1'b0;
        a_dvd   = 4'd2;
        a_dvs   = 4'd1;
        btnres  = 1'b1;
        wait_done_a(e, b);
        checks++; if (e !== 6) begin errors++; $display("FAIL reset_auto_latency: got %0d edges expected 6", e); end
        checks++; if (b !== 5) begin errors++; $display("FAIL reset_auto_busy: got %0d cycles expected 5", b); end
        checks++; if ({a_q, a_r, a_dz} !== {4'd2, 4'd0, 1'b0}) begin errors++; $display("FAIL reset_auto_result: got q=%0d r=%0d dz=%b expected q=2 r=0 dz=0", a_q, a_r, a_dz); end
        checks++; if ({m_busy, m_done} !== 2'b00) begin errors++; $display("FAIL reset_manual_idle: got busy/done %b expected 00", {m_busy, m_done}); end
    endtask

    task automatic test_start_manual();
        int e, b;
        @(negedge clk);
        m_dvd   = 4'd13;
        m_dvs   = 4'd4;
        m_start = 1'b1;
        wait_done_m(e, b);
        checks++; if (e !== 6) begin errors++; $display("FAIL start_latency: got %0d edges expected 6", e); end
        checks++; if (b !== 5) begin errors++; $display("FAIL start_busy: got %0d cycles expected 5", b); end
        checks++; if ({m_q, m_r, m_dz} !== {4'd3, 4'd1, 1'b0}) begin errors++; $display("FAIL start_result: got q=%0d r=%0d dz=%b expected q=3 r=1 dz=0", m_q, m_r, m_dz); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({m_done, m_busy, m_q, m_r, m_dz} !== {1'b1, 1'b0, 4'd3, 4'd1, 1'b0}) begin
                errors++;
                $display("FAIL start_hold[%0d]: got done=%b busy=%b q=%0d r=%0d dz=%b expected done=1 busy=0 q=3 r=1 dz=0",
                         i, m_done, m_busy, m_q, m_r, m_dz);
            end
        end
    endtask

    task automatic test_div_zero();
        int e, b;
        @(negedge clk);
        m_dvd   = 4'd9;
        m_dvs   = 4'd0;
        m_start = 1'b1;
        wait_done_m(e, b);
        checks++; if (e !== 2) begin errors++; $display("FAIL dz_latency: got %0d edges expected 2", e); end
        checks++; if ({m_q, m_r, m_dz} !== {4'hF, 4'd9, 1'b1}) begin errors++; $display("FAIL dz_result: got q=%0d r=%0d dz=%b expected q=15 r=9 dz=1", m_q, m_r, m_dz); end
        @(negedge clk);
        m_dvs   = 4'd3;
        m_start = 1'b1;
        wait_done_m(e, b);
        checks++; if (e !== 6) begin errors++; $display("FAIL dz_clear_latency: got %0d edges expected 6", e); end
        checks++; if ({m_q, m_r, m_dz} !== {4'd3, 4'd0, 1'b0}) begin errors++; $display("FAIL dz_clear_result: got q=%0d r=%0d dz=%b expected q=3 r=0 dz=0", m_q, m_r, m_dz); end
    endtask

    task automatic test_midcalc_change();
        int e, b;
        @(negedge clk);
        a_dvd = 4'd7;
        a_dvs = 4'd2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({a_busy, a_done, a_q, a_r} !== {1'b1, 1'b0, 4'd2, 4'd0}) begin errors++; $display("FAIL midcalc_outputs_held: got busy=%b done=%b q=%0d r=%0d expected busy=1 done=0 q=2 r=0", a_busy, a_done, a_q, a_r); end
        a_dvd = 4'd15;
        a_dvs = 4'd15;
        wait_done_a(e, b);
        checks++; if (e !== 3) begin errors++; $display("FAIL midcalc_first_latency: got %0d edges expected 3", e); end
        checks++; if ({a_q, a_r} !== {4'd3, 4'd1}) begin errors++; $display("FAIL midcalc_first_result: got q=%0d r=%0d expected q=3 r=1", a_q, a_r); end
        wait_done_a(e, b);
        checks++; if (e !== 6) begin errors++; $display("FAIL midcalc_restart_latency: got %0d edges expected 6", e); end
        checks++; if ({a_q, a_r, a_dz} !== {4'd1, 4'd0, 1'b0}) begin errors++; $display("FAIL midcalc_restart_result: got q=%0d r=%0d dz=%b expected q=1 r=0 dz=0", a_q, a_r, a_dz); end
    endtask

    task automatic test_back_to_back();
        int last   = -1;
        int pulses = 0;
        @(negedge clk);
        m_dvd   = 4'd14;
        m_dvs   = 4'd5;
        m_start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (m_done) begin
                checks++;
                if (last < 0 && i != 6) begin errors++; $display("FAIL b2b_first_done: got edge %0d expected 6", i); end
                if (last >= 0 && (i - last) != 6) begin errors++; $display("FAIL b2b_period: got %0d edges expected 6", i - last); end
                checks++;
                if ({m_q, m_r} !== {4'd2, 4'd4}) begin errors++; $display("FAIL b2b_result: got q=%0d r=%0d expected q=2 r=4", m_q, m_r); end
                last = i;
                pulses++;
            end
        end
        @(negedge clk);
        m_start = 1'b0;
        checks++; if (pulses !== 5) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 5", pulses); end
    endtask

    task automatic test_reset_midcalc();
        int e, b;
        int seen = 0;
        @(negedge clk);
        m_dvd   = 4'd11;
        m_dvs   = 4'd3;
        m_start = 1'b1;
        @(posedge clk);
        #1;
        m_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        btnres = 1'b0;
        #1;
        checks++; if ({m_busy, m_done, m_dz} !== 3'b000) begin errors++; $display("FAIL abort_status: got %b expected 000", {m_busy, m_done, m_dz}); end
        checks++; if ({m_q, m_r} !== 8'h00) begin errors++; $display("FAIL abort_result: got q=%0d r=%0d expected q=0 r=0", m_q, m_r); end
        @(negedge clk);
        btnres = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_done || m_busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen); end
        m_start = 1'b1;
        wait_done_m(e, b);
        checks++; if (e !== 6) begin errors++; $display("FAIL abort_rerun_latency: got %0d edges expected 6", e); end
        checks++; if ({m_q, m_r, m_dz} !== {4'd3, 4'd2, 1'b0}) begin errors++; $display("FAIL abort_rerun_result: got q=%0d r=%0d dz=%b expected q=3 r=2 dz=0", m_q, m_r, m_dz); end
    endtask

    task automatic test_sweep();
        int         e, b;
        logic [3:0] eq, er;
        logic       edz;
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            m_dvd   = v[7:4];
            m_dvs   = v[3:0];
            m_start = 1'b1;
            if (v[3:0] == 0) begin
                eq  = 4'hF;
                er  = v[7:4];
                edz = 1'b1;
            end else begin
                eq  = 4'(v[7:4] / v[3:0]);
                er  = 4'(v[7:4] % v[3:0]);
                edz = 1'b0;
            end
            wait_done_m(e, b);
            checks++;
            if (e < 0) begin
                errors++;
                $display("FAIL sweep_timeout %0d/%0d: got no done expected done", v[7:4], v[3:0]);
            end else if ({m_q, m_r, m_dz} !== {eq, er, edz}) begin
                errors++;
                $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                         v[7:4], v[3:0], m_q, m_r, m_dz, eq, er, edz);
            end
        end
    endtask

    initial begin
        btnres  = 1'b0;
        a_start = 1'b0;
        m_start = 1'b0;
        a_dvd   = 4'd0;
        a_dvs   = 4'd0;
        m_dvd   = 4'd0;
        m_dvs   = 4'd0;
        test_reset();
        test_start_manual();
        test_div_zero();
        test_midcalc_change();
        test_back_to_back();
        test_reset_midcalc();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
